// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the
// response-slot state type used by the arbiter.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'h0;
   localparam logic [OP_W-1:0] OP_SUB = 4'h1;
   localparam logic [OP_W-1:0] OP_AND = 4'h2;
   localparam logic [OP_W-1:0] OP_OR  = 4'h3;
   localparam logic [OP_W-1:0] OP_XOR = 4'h4;
   localparam logic [OP_W-1:0] OP_SLL = 4'h5;
   localparam logic [OP_W-1:0] OP_SRL = 4'h6;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU; unknown opcodes yield zero so the flag stays
// consistent with the result.
module alu_32bit
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLL:  result = a << b[4:0];
         OP_SRL:  result = a >> b[4:0];
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one alu_32bit among NUM_REQ requesters, with a
// single registered valid/ready response slot.
module alu_rr_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_zero
);

   slot_state_t       state, state_next;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic              slot_free;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [OP_W-1:0]   alu_op;
   logic              alu_zero;
   logic [ID_W-1:0]   id_next;
   logic [DATA_W-1:0] result_next;
   logic              zero_next;

   assign rsp_valid = (state == FULL);
   assign slot_free = (state == EMPTY) || rsp_ready;

   // First valid requester at or after rr_ptr wins, wrapping around.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      req_ready = '0;
      if (slot_free) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = ID_W'(idx);
            end
         end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   assign alu_a  = req_a[gnt_idx*DATA_W +: DATA_W];
   assign alu_b  = req_b[gnt_idx*DATA_W +: DATA_W];
   assign alu_op = req_op[gnt_idx*OP_W +: OP_W];

   alu_32bit u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // An issue always overwrites the slot, so a drain in the same cycle is implicit.
   always_comb begin
      state_next  = state;
      rr_ptr_next = rr_ptr;
      id_next     = rsp_id;
      result_next = rsp_result;
      zero_next   = rsp_zero;
      if (gnt_any) begin
         state_next  = FULL;
         id_next     = gnt_idx;
         result_next = alu_result;
         zero_next   = alu_zero;
         rr_ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end else if ((state == FULL) && rsp_ready) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         rr_ptr     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         state      <= state_next;
         rr_ptr     <= rr_ptr_next;
         rsp_id     <= id_next;
         rsp_result <= result_next;
         rsp_zero   <= zero_next;
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: opcode vector table plus
// round-robin, backpressure and async-reset sequences against a scoreboard.
module tb_alu_rr_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [N*4-1:0]  req_op;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_result;
   logic          rsp_zero;

   int nApplied = 0;
   int nMiss    = 0;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        zero;
   } vec_t;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   vec_t vecs[10];
   exp_t sbq[$];
   int   mptr;

   alu_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   always #5 clk = ~clk;

   // Reference ALU: {zero, result}
   function automatic logic [32:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      logic [31:0] r;
      case (op)
         4'h0:    r = a + b;
         4'h1:    r = a - b;
         4'h2:    r = a & b;
         4'h3:    r = a | b;
         4'h4:    r = a ^ b;
         4'h5:    r = a << b[4:0];
         4'h6:    r = a >> b[4:0];
         default: r = 32'h0;
      endcase
      return {(r == 32'h0), r};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op);
      req_a[32*idx +: 32] = a;
      req_b[32*idx +: 32] = b;
      req_op[4*idx +: 4]  = op;
      req_valid[idx]      = 1'b1;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sbq.delete();
      mptr = 0;
   endtask

   // One clock: check grant and response at the negedge, update the model, advance.
   task automatic stepCycle(output int gnt);
      logic [3:0]  expReady;
      logic [32:0] r;
      exp_t        e;
      bit          freeSlot;
      @(negedge clk);
      freeSlot = (sbq.size() == 0) || rsp_ready;
      gnt = -1;
      if (freeSlot) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (gnt < 0 && req_valid[j]) gnt = j;
         end
      end
      expReady = (gnt >= 0) ? (4'b0001 << gnt) : 4'b0000;
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("rsp_valid", 32'(rsp_valid), (sbq.size() != 0) ? 32'd1 : 32'd0);
      if (sbq.size() != 0) begin
         checkOutput("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
         checkOutput("rsp_result", rsp_result, sbq[0].res);
         checkOutput("rsp_zero", 32'(rsp_zero), 32'(sbq[0].zero));
         if (rsp_ready) void'(sbq.pop_front());
      end
      if (gnt >= 0) begin
         r      = aluRef(req_a[32*gnt +: 32], req_b[32*gnt +: 32], req_op[4*gnt +: 4]);
         e.id   = 2'(gnt);
         e.res  = r[31:0];
         e.zero = r[32];
         sbq.push_back(e);
         mptr = (gnt + 1) % N;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;

      vecs[0] = '{0, 32'd5,          32'd3,          4'h0, 32'd8,          1'b0};
      vecs[1] = '{2, 32'd7,          32'd7,          4'h1, 32'd0,          1'b1};
      vecs[2] = '{1, 32'd123,        32'd9,          4'hF, 32'd0,          1'b1};
      vecs[3] = '{3, 32'h8000_0000,  32'd33,         4'h6, 32'h4000_0000,  1'b0};
      vecs[4] = '{0, 32'hFFFF_FFFF,  32'd1,          4'h0, 32'd0,          1'b1};
      vecs[5] = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  4'h2, 32'h0000_00F0,  1'b0};
      vecs[6] = '{2, 32'h0000_F000,  32'h0000_000F,  4'h3, 32'h0000_F00F,  1'b0};
      vecs[7] = '{3, 32'hAAAA_5555,  32'hFFFF_0000,  4'h4, 32'h5555_5555,  1'b0};
      vecs[8] = '{0, 32'h0000_0003,  32'd36,         4'h5, 32'h0000_0030,  1'b0};
      vecs[9] = '{1, 32'd10,         32'd20,         4'h1, 32'hFFFF_FFF6,  1'b0};

      doReset();
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("reset_rsp_result", rsp_result, 32'd0);
      checkOutput("reset_rsp_zero", 32'(rsp_zero), 32'd0);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

      $display("[TB] opcode vector table");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].op);
         stepCycle(g);
         req_valid[vecs[i].idx] = 1'b0;
         checkOutput("vec_valid", 32'(rsp_valid), 32'd1);
         checkOutput("vec_id", 32'(rsp_id), 32'(vecs[i].idx));
         checkOutput("vec_result", rsp_result, vecs[i].res);
         checkOutput("vec_zero", 32'(rsp_zero), 32'(vecs[i].zero));
      end
      stepCycle(g);

      $display("[TB] round robin, all requesters held");
      doReset();
      for (int i = 0; i < N; i++) applyStimulus(i, 32'(100 + i), 32'(i + 1), 4'(i));
      for (int k = 0; k < 5; k++) begin
         stepCycle(g);
         checkOutput("rr_rsp_id", 32'(rsp_id), 32'(k % N));
      end
      req_valid = '0;
      stepCycle(g);
      stepCycle(g);

      $display("[TB] backpressure");
      applyStimulus(0, 32'h1, 32'd4, 4'h5);
      stepCycle(g);
      req_valid[0] = 1'b0;
      rsp_ready    = 1'b0;
      applyStimulus(1, 32'h0000_00A8, 32'h3, 4'h3);
      for (int k = 0; k < 3; k++) begin
         stepCycle(g);
         checkOutput("bp_hold_result", rsp_result, 32'h10);
         checkOutput("bp_hold_id", 32'(rsp_id), 32'd0);
      end
      rsp_ready = 1'b1;
      stepCycle(g);
      req_valid[1] = 1'b0;
      checkOutput("bp_regrant_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_regrant_result", rsp_result, 32'h0000_00AB);
      stepCycle(g);

      $display("[TB] async reset during stall");
      applyStimulus(2, 32'd9, 32'd1, 4'h0);
      rsp_ready = 1'b0;
      stepCycle(g);
      req_valid[2] = 1'b0;
      checkOutput("ar_pre_valid", 32'(rsp_valid), 32'd1);
      checkOutput("ar_pre_result", rsp_result, 32'd10);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("ar_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("ar_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("ar_rsp_result", rsp_result, 32'd0);
      checkOutput("ar_rsp_zero", 32'(rsp_zero), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sbq.delete();
      mptr      = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) applyStimulus(i, 32'(i), 32'd0, 4'h3);
      stepCycle(g);
      checkOutput("ar_first_grant_id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      stepCycle(g);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
      $finish;
   end

endmodule
